// File: rtl/line_fill_buffer_if.sv
// Bus bundle for the line fill buffer: miss request, memory read channel,
// and the assembled-line delivery channel.
interface line_fill_buffer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WORD_WIDTH = 32
);
  logic                    req_valid;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_ready;
  logic                    flush;
  logic                    mem_read;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_ready;
  logic [WORD_WIDTH-1:0]   mem_rdata;
  logic                    mem_rvalid;
  logic                    line_valid;
  logic [4*WORD_WIDTH-1:0] line_data;
  logic [ADDR_WIDTH-1:0]   line_addr;
  logic [1:0]              word_sel;
  logic                    line_ack;

  // Buffer side.
  modport slave (
    input  req_valid, req_addr, flush, mem_ready, mem_rdata, mem_rvalid, line_ack,
    output req_ready, mem_read, mem_addr, line_valid, line_data, line_addr, word_sel
  );

  // Cache controller / memory side.
  modport master (
    output req_valid, req_addr, flush, mem_ready, mem_rdata, mem_rvalid, line_ack,
    input  req_ready, mem_read, mem_addr, line_valid, line_data, line_addr, word_sel
  );
endinterface

// File: rtl/line_fill_buffer.sv
// Line fill buffer: accepts one miss request, issues a line-aligned memory
// read, assembles four in-order beats into a line and holds it until acked.
// A flush abandons the fill; any beats still owed by memory are drained.
module line_fill_buffer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  line_fill_buffer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FILL,
    DRAIN,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [4*WORD_WIDTH-1:0] line_data_q, line_data_d;
  logic [ADDR_WIDTH-1:0]   line_addr_q, line_addr_d;
  logic [1:0]              word_sel_q, word_sel_d;

  // Byte-offset bits below the word select are not needed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.req_addr[1:0];

  // Next-state, beat counter and line capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_data_d = line_data_q;
    line_addr_d = line_addr_q;
    word_sel_d  = word_sel_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          line_addr_d = {bus.req_addr[ADDR_WIDTH-1:4], 4'b0000};
          word_sel_d  = bus.req_addr[3:2];
          cnt_d       = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        // Once memory has taken the command, four beats are owed even if flushed.
        if (bus.mem_ready) begin
          state_d = bus.flush ? DRAIN : FILL;
        end else if (bus.flush) begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (bus.mem_rvalid) begin
          for (int unsigned k = 0; k < 4; k++) begin
            if (cnt_q == 2'(k)) begin
              line_data_d[k*WORD_WIDTH +: WORD_WIDTH] = bus.mem_rdata;
            end
          end
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = bus.flush ? IDLE : DONE;
          end else if (bus.flush) begin
            state_d = DRAIN;
          end
        end else if (bus.flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.mem_rvalid) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        if (bus.line_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      line_data_q <= '0;
      line_addr_q <= '0;
      word_sel_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_data_q <= line_data_d;
      line_addr_q <= line_addr_d;
      word_sel_q  <= word_sel_d;
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.mem_read   = (state_q == REQ);
    bus.mem_addr   = line_addr_q;
    bus.line_valid = (state_q == DONE);
    bus.line_data  = line_data_q;
    bus.line_addr  = line_addr_q;
    bus.word_sel   = word_sel_q;
  end

endmodule

// File: tb/tb_line_fill_buffer.sv
// Self-checking bench for line_fill_buffer: directed and randomized fills,
// flush handling and asynchronous reset, checked against a line-level model.
module tb_line_fill_buffer;
  localparam int unsigned AW = 32;
  localparam int unsigned WW = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  line_fill_buffer_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

  line_fill_buffer #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.flush      = 1'b0;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = '0;
    bus.mem_rvalid = 1'b0;
    bus.line_ack   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b want 1", bus.req_ready); end
    checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read got %0b want 0", bus.mem_read); end
    checks++; if (bus.line_valid !== 1'b0) begin errors++; $display("FAIL reset_line_valid got %0b want 0", bus.line_valid); end
    checks++; if (bus.line_data !== '0) begin errors++; $display("FAIL reset_line_data got %h want 0", bus.line_data); end
    checks++; if (bus.line_addr !== '0) begin errors++; $display("FAIL reset_line_addr got %h want 0", bus.line_addr); end
    checks++; if (bus.word_sel !== 2'd0) begin errors++; $display("FAIL reset_word_sel got %0d want 0", bus.word_sel); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [4*WW-1:0] exp_line;
    exp_line = 128'h000000A3_000000A2_000000A1_000000A0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_1238;
    bus.mem_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    checks++; if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL dir_mem_read got %0b want 1", bus.mem_read); end
    checks++; if (bus.mem_addr !== 32'h0000_1230) begin errors++; $display("FAIL dir_mem_addr got %h want 00001230", bus.mem_addr); end
    checks++; if (bus.word_sel !== 2'd2) begin errors++; $display("FAIL dir_word_sel got %0d want 2", bus.word_sel); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL dir_req_ready got %0b want 0", bus.req_ready); end
    tick();
    bus.mem_ready = 1'b0;
    checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL dir_mem_read_drop got %0b want 0", bus.mem_read); end
    for (int k = 0; k < 4; k++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hA0 + 32'(k);
      tick();
      bus.mem_rvalid = 1'b0;
      if (k < 3) begin
        checks++; if (bus.line_valid !== 1'b0) begin errors++; $display("FAIL dir_early_valid beat %0d got %0b want 0", k, bus.line_valid); end
      end
    end
    checks++; if (bus.line_valid !== 1'b1) begin errors++; $display("FAIL dir_line_valid got %0b want 1", bus.line_valid); end
    checks++; if (bus.line_data !== exp_line) begin errors++; $display("FAIL dir_line_data got %h want %h", bus.line_data, exp_line); end
    checks++; if (bus.line_addr !== 32'h0000_1230) begin errors++; $display("FAIL dir_line_addr got %h want 00001230", bus.line_addr); end
    bus.line_ack = 1'b1;
    tick();
    bus.line_ack = 1'b0;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL dir_idle_after_ack got %0b want 1", bus.req_ready); end
  endtask

  // Randomized fills: memory stalls, beat gaps, delayed ack, ignored side traffic.
  task automatic test_random_fills();
    logic [AW-1:0]   addr, exp_addr;
    logic [1:0]      exp_ws;
    logic [WW-1:0]   beats [4];
    logic [4*WW-1:0] exp_line;
    int unsigned     rd, gap, ackd;
    for (int it = 0; it < 12; it++) begin
      addr = $urandom;
      rd   = (it == 0) ? 3 : $urandom_range(0, 3);
      gap  = (it == 0) ? 2 : $urandom_range(0, 2);
      ackd = (it == 0) ? 5 : $urandom_range(0, 5);
      for (int k = 0; k < 4; k++) beats[k] = $urandom;
      exp_line = {beats[3], beats[2], beats[1], beats[0]};
      exp_addr = addr & ~32'hF;
      exp_ws   = addr[3:2];

      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rnd_start_ready it %0d got %0b want 1", it, bus.req_ready); end
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      tick();
      bus.req_valid = 1'b0;
      for (int unsigned i = 0; i < rd; i++) begin
        checks++; if ({bus.mem_read, bus.mem_addr} !== {1'b1, exp_addr}) begin errors++; $display("FAIL rnd_stall_cmd it %0d got %0b/%h want 1/%h", it, bus.mem_read, bus.mem_addr, exp_addr); end
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rnd_stall_ready it %0d got %0b want 0", it, bus.req_ready); end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = $urandom;
        tick();
        bus.mem_rvalid = 1'b0;
      end
      checks++; if ({bus.mem_read, bus.mem_addr} !== {1'b1, exp_addr}) begin errors++; $display("FAIL rnd_cmd it %0d got %0b/%h want 1/%h", it, bus.mem_read, bus.mem_addr, exp_addr); end
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready = 1'b0;
      checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL rnd_read_drop it %0d got %0b want 0", it, bus.mem_read); end
      for (int k = 0; k < 4; k++) begin
        for (int unsigned g = 0; g < gap; g++) begin
          bus.req_valid = 1'($urandom_range(0, 1));
          bus.req_addr  = $urandom;
          tick();
          checks++; if ({bus.line_valid, bus.req_ready} !== 2'b00) begin errors++; $display("FAIL rnd_gap it %0d got valid/ready %0b%0b want 00", it, bus.line_valid, bus.req_ready); end
        end
        bus.req_valid  = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = beats[k];
        tick();
        bus.mem_rvalid = 1'b0;
        if (k < 3) begin
          checks++; if (bus.line_valid !== 1'b0) begin errors++; $display("FAIL rnd_early_valid it %0d beat %0d got %0b want 0", it, k, bus.line_valid); end
        end
      end
      checks++; if (bus.line_valid !== 1'b1) begin errors++; $display("FAIL rnd_line_valid it %0d got %0b want 1", it, bus.line_valid); end
      checks++; if (bus.line_data !== exp_line) begin errors++; $display("FAIL rnd_line_data it %0d got %h want %h", it, bus.line_data, exp_line); end
      checks++; if (bus.line_addr !== exp_addr) begin errors++; $display("FAIL rnd_line_addr it %0d got %h want %h", it, bus.line_addr, exp_addr); end
      checks++; if (bus.word_sel !== exp_ws) begin errors++; $display("FAIL rnd_word_sel it %0d got %0d want %0d", it, bus.word_sel, exp_ws); end
      for (int unsigned d = 0; d < ackd; d++) begin
        bus.flush      = 1'($urandom_range(0, 1));
        bus.mem_rvalid = 1'($urandom_range(0, 1));
        bus.mem_rdata  = $urandom;
        bus.req_valid  = 1'($urandom_range(0, 1));
        tick();
        checks++; if ({bus.line_valid, bus.req_ready} !== 2'b10) begin errors++; $display("FAIL rnd_hold it %0d got valid/ready %0b%0b want 10", it, bus.line_valid, bus.req_ready); end
        checks++; if (bus.line_data !== exp_line) begin errors++; $display("FAIL rnd_hold_data it %0d got %h want %h", it, bus.line_data, exp_line); end
      end
      bus.flush      = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.line_ack   = 1'b1;
      bus.req_valid  = 1'b1;
      bus.req_addr   = $urandom;
      tick();
      bus.line_ack  = 1'b0;
      bus.req_valid = 1'b0;
      checks++; if ({bus.line_valid, bus.req_ready, bus.mem_read} !== 3'b010) begin errors++; $display("FAIL rnd_after_ack it %0d got valid/ready/read %0b%0b%0b want 010", it, bus.line_valid, bus.req_ready, bus.mem_read); end
    end
  endtask

  task automatic test_flush_req();
    // flush in IDLE does not block acceptance
    bus.req_valid = 1'b1;
    bus.req_addr  = $urandom;
    bus.flush     = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    checks++; if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL flreq_idle_flush got %0b want 1", bus.mem_read); end
    // flush before acceptance abandons outright
    tick();
    bus.flush = 1'b0;
    checks++; if ({bus.req_ready, bus.mem_read} !== 2'b10) begin errors++; $display("FAIL flreq_abandon got ready/read %0b%0b want 10", bus.req_ready, bus.mem_read); end
    // flush with acceptance must still absorb four beats
    bus.req_valid = 1'b1;
    bus.req_addr  = $urandom;
    tick();
    bus.req_valid = 1'b0;
    bus.flush     = 1'b1;
    bus.mem_ready = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if ({bus.line_valid, bus.req_ready, bus.mem_read} !== 3'b000) begin errors++; $display("FAIL flreq_drain beat %0d got valid/ready/read %0b%0b%0b want 000", k, bus.line_valid, bus.req_ready, bus.mem_read); end
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = $urandom;
      tick();
      bus.mem_rvalid = 1'b0;
    end
    checks++; if ({bus.line_valid, bus.req_ready} !== 2'b01) begin errors++; $display("FAIL flreq_drain_end got valid/ready %0b%0b want 01", bus.line_valid, bus.req_ready); end
  endtask

  // Flush at a random point in the fill, with or without a same-cycle beat.
  task automatic test_flush_fill();
    int unsigned n_pre, same, remaining;
    for (int it = 0; it < 8; it++) begin
      if (it == 0) begin
        n_pre = 2;
        same  = 0;
      end else begin
        n_pre = $urandom_range(0, 3);
        same  = $urandom_range(0, 1);
      end
      remaining = same ? (3 - n_pre) : (4 - n_pre);
      bus.req_valid = 1'b1;
      bus.req_addr  = $urandom;
      bus.mem_ready = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      tick();
      bus.mem_ready = 1'b0;
      for (int unsigned k = 0; k < n_pre; k++) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = $urandom;
        tick();
        bus.mem_rvalid = 1'b0;
      end
      bus.flush      = 1'b1;
      bus.mem_rvalid = 1'(same);
      bus.mem_rdata  = $urandom;
      tick();
      bus.flush      = 1'b0;
      bus.mem_rvalid = 1'b0;
      for (int unsigned r = 0; r < remaining; r++) begin
        checks++; if ({bus.line_valid, bus.req_ready} !== 2'b00) begin errors++; $display("FAIL flfill_drain it %0d r %0d got valid/ready %0b%0b want 00", it, r, bus.line_valid, bus.req_ready); end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = $urandom;
        tick();
        bus.mem_rvalid = 1'b0;
      end
      checks++; if ({bus.line_valid, bus.req_ready} !== 2'b01) begin errors++; $display("FAIL flfill_end it %0d pre %0d same %0d got valid/ready %0b%0b want 01", it, n_pre, same, bus.line_valid, bus.req_ready); end
      tick();
      checks++; if (bus.line_valid !== 1'b0) begin errors++; $display("FAIL flfill_late_valid it %0d got %0b want 0", it, bus.line_valid); end
    end
  endtask

  task automatic test_reset_mid_fill();
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'hDEAD_BEEC;
    bus.mem_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    bus.mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = $urandom | 32'h1;
      tick();
      bus.mem_rvalid = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.line_data !== '0) begin errors++; $display("FAIL rst_async_data got %h want 0", bus.line_data); end
    checks++; if ({bus.line_addr, bus.word_sel} !== '0) begin errors++; $display("FAIL rst_async_addr got %h/%0d want 0/0", bus.line_addr, bus.word_sel); end
    checks++; if ({bus.line_valid, bus.mem_read, bus.req_ready} !== 3'b001) begin errors++; $display("FAIL rst_async_ctrl got valid/read/ready %0b%0b%0b want 001", bus.line_valid, bus.mem_read, bus.req_ready); end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = $urandom | 32'h1;
      tick();
    end
    bus.mem_rvalid = 1'b0;
    checks++; if (bus.line_data !== '0) begin errors++; $display("FAIL rst_stray_data got %h want 0", bus.line_data); end
    checks++; if ({bus.line_valid, bus.req_ready} !== 2'b01) begin errors++; $display("FAIL rst_stray_ctrl got valid/ready %0b%0b want 01", bus.line_valid, bus.req_ready); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_fills();
    test_flush_req();
    test_flush_fill();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_fill_buffer.md
LINE_FILL_BUFFER -- requirements
Module: line_fill_buffer

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, byte-address width of request and memory address.
REQ-002 Parameter: WORD_WIDTH, 32, memory beat width; line width SHALL be 4*WORD_WIDTH (128 by default).
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: req_valid  input  1  miss request from cache controller.
REQ-006 Port: req_addr  input  ADDR_WIDTH  byte address of missing word.
REQ-007 Port: req_ready  output  1  buffer can accept a request.
REQ-008 Port: flush  input  1  abandon current fill (pipeline redirect).
REQ-009 Port: mem_read  output  1  read command to memory.
REQ-010 Port: mem_addr  output  ADDR_WIDTH  line-aligned address, low 4 bits zero.
REQ-011 Port: mem_ready  input  1  memory accepts command.
REQ-012 Port: mem_rdata  input  WORD_WIDTH  returned beat.
REQ-013 Port: mem_rvalid  input  1  mem_rdata valid this cycle.
REQ-014 Port: line_valid  output  1  assembled line available.
REQ-015 Port: line_data  output  4*WORD_WIDTH  assembled line; beat k in bits [WORD_WIDTH*(k+1)-1 : WORD_WIDTH*k].
REQ-016 Port: line_addr  output  ADDR_WIDTH  line-aligned address of line_data.
REQ-017 Port: word_sel  output  2  captured req_addr[3:2]; drives the downstream 4:1 word select mux.
REQ-018 Port: line_ack  input  1  consumer has taken the line.

Function
REQ-019 FSM states SHALL be IDLE, REQ, FILL, DRAIN, DONE.
REQ-020 IDLE: req_ready=1; on req_valid, capture {req_addr[ADDR_WIDTH-1:4],4'b0} into line_addr and req_addr[3:2] into word_sel, clear beat counter, go to REQ next cycle.
REQ-021 REQ: mem_read=1, mem_addr=line_addr; on mem_ready go to FILL; mem_read SHALL drop the cycle after acceptance.
REQ-022 FILL: on each mem_rvalid, write mem_rdata into beat slot indexed by 2-bit counter, then increment counter; beats arrive in order 0,1,2,3.
REQ-023 FILL: on the 4th mem_rvalid (counter==3) go to DONE; counter SHALL wrap to 0.
REQ-024 DONE: line_valid=1 with line_data, line_addr, word_sel stable; on line_ack go to IDLE next cycle.
REQ-025 req_ready SHALL be 1 only in IDLE; requests in other states are not accepted (line_ack with req_valid in DONE accepts nothing that cycle).
REQ-026 mem_rvalid outside FILL and DRAIN SHALL be ignored; line_data unchanged.
REQ-027 flush in IDLE or DONE SHALL be ignored (DONE line still delivered).
REQ-028 flush in REQ before mem_ready SHALL return to IDLE; flush with mem_ready in the same cycle SHALL go to DRAIN.
REQ-029 flush in FILL SHALL go to DRAIN, counting the same-cycle beat if mem_rvalid; DRAIN consumes remaining beats of 4 without asserting line_valid, then goes to IDLE.
REQ-030 flush on the 4th beat SHALL go to IDLE, not DONE.
REQ-031 Latency: line_valid SHALL rise the cycle after the 4th mem_rvalid.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, counter=0, line_data=0, line_addr=0, word_sel=0, mem_read=0, line_valid=0; req_ready=1 while in IDLE.
REQ-033 Reset mid-fill SHALL discard partial line; beats arriving after reset release are ignored.

Verification
REQ-034 req_addr=0x0000_1238, mem_ready=1, beats 0xA0,0xA1,0xA2,0xA3 back-to-back -> mem_addr=0x0000_1230, word_sel=2, line_data=0x000000A3_000000A2_000000A1_000000A0, line_valid one cycle after beat 3.
REQ-035 Beats with 2-cycle gaps, line_ack delayed 5 cycles -> line_valid held 5+ cycles, req_ready=0 throughout, IDLE after ack.
REQ-036 mem_ready held low 3 cycles -> mem_read held high with constant mem_addr, no FILL entry.
REQ-037 flush after beat 1 -> DRAIN, beats 2-3 absorbed, line_valid never asserts, req_ready=1 after beat 3.
REQ-038 rst_n low after beat 2 -> all outputs zero asynchronously; stray mem_rvalid after release leaves line_data=0.
